// File: rtl/m_imem_loader.sv
// Byte-stream program loader: length header, then little-endian words written to instruction RAM.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before releasing the core.
module m_imem_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rx_valid,
  input  logic [7:0]        w_rx_data,
  output logic              w_rx_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_wdata,
  output logic              w_ce,
  output logic              w_busy,
  output logic              w_err,
  output logic [ADDR_W:0]   w_count
);

  typedef enum logic [2:0] {StHdr, StData, StWrite, StChk, StRun, StErr} state_e;

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [23:0]     shift_q;
  logic [ADDR_W:0] n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]     csum_q;
`endif

  logic            accept;
  logic            last_byte;
  logic [31:0]     word;
  logic [ADDR_W:0] count_inc;

  assign accept    = w_rx_valid & w_rx_ready;
  assign last_byte = accept && (idx_q == 2'd3);
  // Earlier bytes sit in the low bits, so the incoming byte lands on top.
  assign word      = {w_rx_data, shift_q};
  assign count_inc = w_count + 1'b1;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= StHdr;
      idx_q      <= 2'd0;
      shift_q    <= '0;
      n_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      w_rx_ready <= 1'b0;
      w_we       <= 1'b0;
      w_addr     <= '0;
      w_wdata    <= '0;
      w_ce       <= 1'b0;
      w_busy     <= 1'b0;
      w_err      <= 1'b0;
      w_count    <= '0;
    end else begin
      w_we <= 1'b0;
      if (accept) begin
        shift_q <= word[31:8];
        idx_q   <= idx_q + 2'd1;
      end
      case (state_q)
        StHdr: begin
          w_rx_ready <= 1'b1;
          if (accept) w_busy <= 1'b1;
          if (last_byte) begin
            if (word > MAX_WORDS) begin
              state_q    <= StErr;
              w_err      <= 1'b1;
              w_rx_ready <= 1'b0;
              w_busy     <= 1'b0;
            end else if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q    <= StChk;
`else
              state_q    <= StRun;
              w_ce       <= 1'b1;
              w_rx_ready <= 1'b0;
              w_busy     <= 1'b0;
`endif
            end else begin
              n_q     <= word[ADDR_W:0];
              state_q <= StData;
            end
          end
        end
        StData: begin
          w_rx_ready <= 1'b1;
          if (last_byte) begin
            state_q    <= StWrite;
            w_we       <= 1'b1;
            w_wdata    <= word;
            w_rx_ready <= 1'b0;
          end
        end
        StWrite: begin
          w_addr  <= w_addr + 1'b1;
          w_count <= count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_q  <= csum_q ^ w_wdata;
`endif
          if (count_inc == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= StChk;
            w_rx_ready <= 1'b1;
`else
            state_q    <= StRun;
            w_ce       <= 1'b1;
            w_busy     <= 1'b0;
`endif
          end else begin
            state_q    <= StData;
            w_rx_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: begin
          w_rx_ready <= 1'b1;
          if (last_byte) begin
            w_rx_ready <= 1'b0;
            w_busy     <= 1'b0;
            if (word == csum_q) begin
              state_q <= StRun;
              w_ce    <= 1'b1;
            end else begin
              state_q <= StErr;
              w_err   <= 1'b1;
            end
          end
        end
`endif
        default: ;  // StRun and StErr are terminal until reset
      endcase
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader: directed and randomized loads against a
// program-level model (expected writes, word count, checksum, final run/error outcome).
module tb_m_imem_loader;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MAX_WORDS = 4096;

  logic              w_clk = 1'b0;
  logic              w_rst_n;
  logic              w_rx_valid;
  logic [7:0]        w_rx_data;
  logic              w_rx_ready;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_ce;
  logic              w_busy;
  logic              w_err;
  logic [ADDR_W:0]   w_count;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt;
  logic [31:0] prog[$];

  m_imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_rx_valid (w_rx_valid),
    .w_rx_data  (w_rx_data),
    .w_rx_ready (w_rx_ready),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_wdata    (w_wdata),
    .w_ce       (w_ce),
    .w_busy     (w_busy),
    .w_err      (w_err),
    .w_count    (w_count)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) we_cnt <= 0;
    else if (w_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xor_prog();
    logic [31:0] x = '0;
    foreach (prog[i]) x ^= prog[i];
    return x;
  endfunction

  function automatic int pick_gap(input int gmin, input int gmax);
    return int'($urandom_range(gmax, gmin));
  endfunction

  task automatic do_reset();
    w_rst_n    = 1'b0;
    w_rx_valid = 1'b0;
    w_rx_data  = 8'h00;
    repeat (2) @(negedge w_clk);
    w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;
  endtask

  // Returns 1 time unit after the posedge that transferred the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    w_rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge w_clk);
      #1;
    end
    w_rx_valid = 1'b1;
    w_rx_data  = b;
    forever begin
      @(negedge w_clk);
      if (w_rx_ready) break;
      budget++;
      if (budget > 40) begin
        check("rx_ready_timeout", {31'd0, w_rx_ready}, 32'd1);
        break;
      end
    end
    @(posedge w_clk);
    #1;
    w_rx_valid = 1'b0;
  endtask

  // Streams header, prog words and (checksum build) csum; checks each write and the outcome.
  task automatic run_load(input string tag, input logic [31:0] hdr_n, input int gmin,
                          input int gmax, input logic [31:0] csum);
    logic        chk_en;
    logic        exp_err;
    logic [31:0] exp_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    exp_err = (hdr_n > MAX_WORDS) || (chk_en && (csum != xor_prog()));
    exp_n   = (hdr_n > MAX_WORDS) ? 32'd0 : hdr_n;
    check({tag, ".busy_idle"}, {31'd0, w_busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      send_byte(hdr_n[8*k +: 8], pick_gap(gmin, gmax));
      if (k == 0) check({tag, ".busy_hdr"}, {31'd0, w_busy}, 32'd1);
    end
    if (hdr_n <= MAX_WORDS) begin
      for (int i = 0; i < int'(hdr_n); i++) begin
        for (int k = 0; k < 4; k++) send_byte(prog[i][8*k +: 8], pick_gap(gmin, gmax));
        @(negedge w_clk);
        check($sformatf("%s.we%0d", tag, i), {31'd0, w_we}, 32'd1);
        check($sformatf("%s.addr%0d", tag, i), {20'd0, w_addr}, i);
        check($sformatf("%s.wdata%0d", tag, i), w_wdata, prog[i]);
        check($sformatf("%s.ce_load%0d", tag, i), {31'd0, w_ce}, 32'd0);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      for (int k = 0; k < 4; k++) send_byte(csum[8*k +: 8], pick_gap(gmin, gmax));
`endif
    end
    @(negedge w_clk);
    #1;
    check({tag, ".ce"}, {31'd0, w_ce}, {31'd0, !exp_err});
    check({tag, ".err"}, {31'd0, w_err}, {31'd0, exp_err});
    check({tag, ".count"}, {19'd0, w_count}, exp_n);
    check({tag, ".writes"}, we_cnt, exp_n);
    check({tag, ".busy_end"}, {31'd0, w_busy}, 32'd0);
    check({tag, ".ready_end"}, {31'd0, w_rx_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] hdr;
    logic [31:0] cs;
    int          n;

    w_rst_n    = 1'b0;
    w_rx_valid = 1'b0;
    w_rx_data  = 8'h00;
    repeat (2) @(negedge w_clk);
    check("rst.we", {31'd0, w_we}, 32'd0);
    check("rst.ce", {31'd0, w_ce}, 32'd0);
    check("rst.err", {31'd0, w_err}, 32'd0);
    check("rst.busy", {31'd0, w_busy}, 32'd0);
    check("rst.ready", {31'd0, w_rx_ready}, 32'd0);
    check("rst.count", {19'd0, w_count}, 32'd0);
    check("rst.addr", {20'd0, w_addr}, 32'd0);
    check("rst.wdata", w_wdata, 32'd0);

    // Single word 0x13.
    do_reset();
    prog = '{32'h0000_0013};
    run_load("one", 32'd1, 0, 0, 32'h0000_0013);

    // N=3, valid toggling every other cycle.
    do_reset();
    prog = '{$urandom, $urandom, $urandom};
    run_load("toggle", 32'd3, 1, 1, xor_prog());

    // Header above the limit.
    do_reset();
    prog.delete();
    run_load("too_big", 32'h0000_1001, 0, 0, 32'd0);

    // Largest legal count is accepted and starts data collection.
    do_reset();
    hdr = MAX_WORDS;
    for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 0);
    @(negedge w_clk);
    check("max.err", {31'd0, w_err}, 32'd0);
    check("max.busy", {31'd0, w_busy}, 32'd1);
    check("max.ready", {31'd0, w_rx_ready}, 32'd1);
    check("max.ce", {31'd0, w_ce}, 32'd0);

    // Empty program.
    do_reset();
    prog.delete();
    run_load("zero", 32'd0, 0, 1, 32'd0);

    // Reset while the 3rd byte of word 1 is on the bus.
    do_reset();
    prog = '{32'hA1B2_C3D4, 32'h0BAD_F00D};
    hdr  = 32'd2;
    for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 0);
    for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 0);
    @(negedge w_clk);
    send_byte(prog[1][7:0], 0);
    send_byte(prog[1][15:8], 0);
    w_rx_valid = 1'b1;
    w_rx_data  = prog[1][23:16];
    @(negedge w_clk);
    w_rst_n = 1'b0;
    #1;
    check("midrst.we", {31'd0, w_we}, 32'd0);
    check("midrst.ce", {31'd0, w_ce}, 32'd0);
    check("midrst.busy", {31'd0, w_busy}, 32'd0);
    check("midrst.ready", {31'd0, w_rx_ready}, 32'd0);
    check("midrst.count", {19'd0, w_count}, 32'd0);
    check("midrst.addr", {20'd0, w_addr}, 32'd0);
    check("midrst.wdata", w_wdata, 32'd0);
    do_reset();
    prog = '{32'h0102_0304, 32'hCAFE_BABE};
    run_load("after_rst", 32'd2, 0, 1, xor_prog());

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    prog = '{32'h1234_5678, 32'h0000_FFFF};
    run_load("csum_ok", 32'd2, 0, 0, 32'h1234_A987);
    do_reset();
    run_load("csum_bad", 32'd2, 0, 0, 32'h0000_0000);
`endif

    for (int r = 0; r < 5; r++) begin
      do_reset();
      prog.delete();
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      cs = xor_prog();
      if ($urandom_range(3, 0) == 0) cs = cs ^ (32'd1 << $urandom_range(31, 0));
      run_load($sformatf("rnd%0d", r), n, 0, 2, cs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
